rand_draw_scheduler: RTL and testbench
======================================

Name: rand_draw_scheduler

Overview:
- Sequences and shares the LFSR random-number generator among NUM_REQ requesters, e.g. board setup, cell filler and hint generator.
- Per draw: steps the LFSR a fixed number of times via gen_rand_flag, then samples lfsr_out.
- Rejection-samples a Sudoku digit 1..9 from lfsr_out[6:3] and returns it, together with a 3-bit setup index from lfsr_out[2:0], to one requester.
- Arbitration between requesters is round-robin.

Parameters:
- NUM_REQ, 3: number of requesters, range 2..8.
- STEP_CNT, 8: LFSR advance cycles per draw attempt, range 1..255.
- MAX_RETRY, 15: rejected attempts allowed before the fallback digit is used, range 1..255.

Ports:
- in_clka  in  1  sole clock; all logic on rising edge.
- in_reset  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester draw request, level; held until that requester's rsp_valid bit.
- lfsr_out  in  24  current LFSR state from the generator.
- gen_rand_flag  out  1  LFSR advance enable.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle response strobe.
- rsp_digit  out  4  accepted digit, 1..9.
- rsp_setup  out  3  lfsr_out[2:0] sampled at acceptance.
- busy  out  1  high in every state except IDLE.
- retry_overflow  out  1  sticky; set when the fallback path is taken.

Behaviour:
- Reset (in_reset high at a clock edge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first; step_cnt=0; retry_cnt=0; grant_idx=0.
  - All outputs 0, including retry_overflow.
  - Reset mid-draw aborts the draw; no rsp_valid is issued and the LFSR is not advanced further.
- IDLE:
  - If any req_valid is high, grant the first set bit scanning from rr_ptr+1 upward with wrap-around.
  - Latch grant_idx, set rr_ptr=grant_idx, clear retry_cnt, go to ADVANCE.
  - With no requests, stay in IDLE.
- ADVANCE:
  - gen_rand_flag=1 for exactly STEP_CNT consecutive cycles; step_cnt counts 0..STEP_CNT-1, then go to SETTLE.
- SETTLE:
  - One cycle with gen_rand_flag=0, letting lfsr_out reflect the final step. Then go to CHECK.
- CHECK: let d=lfsr_out[6:3].
  - If 1<=d<=9: latch rsp_digit=d and rsp_setup=lfsr_out[2:0], go to RESPOND.
  - Else if retry_cnt<MAX_RETRY: retry_cnt++, clear step_cnt, go back to ADVANCE.
  - Else (fallback): rsp_digit=(d mod 9)+1, giving 0→1, 10→2, 15→7; set retry_overflow=1; go to RESPOND.
- RESPOND:
  - rsp_valid[grant_idx]=1 for exactly one cycle; rsp_digit and rsp_setup are valid that same cycle.
  - Then go to IDLE.
  - rsp_digit and rsp_setup hold their values until the next acceptance.
- Latency:
  - With no rejection, rsp_valid rises STEP_CNT+3 cycles after the IDLE cycle that sampled req_valid (11 cycles at default).
  - Each rejection adds STEP_CNT+2 cycles.
- Requester rules:
  - A requester deasserting req_valid before its response does not cancel the draw; the response is still strobed.
  - Requests arriving during a draw wait; arbitration happens only in IDLE.
  - The IDLE cycle following RESPOND may grant immediately; min spacing between responses is STEP_CNT+4 cycles.
- Fairness:
  - A continuously requesting requester is served at most once per NUM_REQ grants while others are requesting.
  - A sole requester is re-granted back-to-back.
- Simultaneous requests: resolved solely by the rotating priority; no index is favoured after the first grant.
- retry_overflow: cleared only by in_reset.
- gen_rand_flag: is 0 in IDLE, SETTLE, CHECK and RESPOND.

Test Plan:
- Reset, then req_valid=3'b001 with lfsr_out driven so [6:3]=5 and [2:0]=6 → gen_rand_flag high for cycles 1-8, rsp_valid=3'b001 at cycle 11, rsp_digit=5, rsp_setup=6, busy low at cycle 12.
- req_valid=3'b111 held continuously with a valid digit each draw → grant order 0,1,2,0,1,2, responses spaced 12 cycles apart.
- lfsr_out[6:3] driven 0, then 12, then 9 → two retries; 3×8=24 gen_rand_flag cycles in total; rsp_digit=9 at cycle 11+2×10=31; retry_overflow stays 0.
- MAX_RETRY=2 with lfsr_out[6:3] stuck at 15 → 3 CHECK passes, then fallback rsp_digit=7; retry_overflow=1 and stays 1 through later normal draws.
- in_reset pulsed during the 4th ADVANCE cycle → next cycle gen_rand_flag=0, no rsp_valid; a subsequent request to requester 2 with 3'b100 only is granted and completes in 11 cycles.
- Requester 1 drops req_valid one cycle after grant → rsp_valid=3'b010 is still issued at cycle 11; no second grant to requester 1.

Source files
------------

// File: rtl/rand_draw_scheduler.sv
// Shares one LFSR among NUM_REQ requesters: steps it, rejection-samples a digit 1..9
// from lfsr_out[6:3] and hands digit plus 3-bit setup index to a round-robin winner.
module rand_draw_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int STEP_CNT  = 8,
    parameter int MAX_RETRY = 15
) (
    input  logic               in_clka,
    input  logic               in_reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [23:0]        lfsr_out,
    output logic               gen_rand_flag,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [3:0]         rsp_digit,
    output logic [2:0]         rsp_setup,
    output logic               busy,
    output logic               retry_overflow
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LAST_STEP = 8'(STEP_CNT - 1);
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_SETTLE,
        S_CHECK,
        S_RESPOND
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] grant_next;
    logic             grant_found;
    logic [7:0]       step_cnt;
    logic [7:0]       retry_cnt;
    logic [3:0]       cand_digit;
    logic             cand_ok;
    logic             unused_lfsr_hi;

    // Only the low seven LFSR bits feed the draw; the rest are folded away.
    assign unused_lfsr_hi = ^lfsr_out[23:7];

    assign cand_digit = lfsr_out[6:3];
    assign cand_ok    = (cand_digit != 4'd0) && (cand_digit <= 4'd9);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        return IDX_W'((int'(base) + offset) % NUM_REQ);
    endfunction

    // Rotating priority: scan starts just after the last winner and wraps.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_next  = rr_ptr;
        grant_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr, i)]) begin
                grant_next  = wrap_idx(rr_ptr, i);
                grant_found = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses <= only, so every register sees pre-edge values of its neighbours.
    always_ff @(posedge in_clka) begin
        if (in_reset) begin
            state          <= S_IDLE;
            rr_ptr         <= IDX_W'(NUM_REQ - 1);
            grant_idx      <= '0;
            step_cnt       <= '0;
            retry_cnt      <= '0;
            gen_rand_flag  <= 1'b0;
            rsp_valid      <= '0;
            rsp_digit      <= '0;
            rsp_setup      <= '0;
            busy           <= 1'b0;
            retry_overflow <= 1'b0;
        end else begin
            rsp_valid <= '0;
            unique case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        grant_idx     <= grant_next;
                        rr_ptr        <= grant_next;
                        retry_cnt     <= '0;
                        step_cnt      <= '0;
                        gen_rand_flag <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (step_cnt == LAST_STEP) begin
                        gen_rand_flag <= 1'b0;
                        state         <= S_SETTLE;
                    end else begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                S_SETTLE: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (cand_ok) begin
                        rsp_digit <= cand_digit;
                        rsp_setup <= lfsr_out[2:0];
                        rsp_valid <= ONE_HOT_0 << grant_idx;
                        state     <= S_RESPOND;
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_cnt     <= retry_cnt + 8'd1;
                        step_cnt      <= '0;
                        gen_rand_flag <= 1'b1;
                        state         <= S_ADVANCE;
                    end else begin
                        // Out of retries: fold the rejected value into 1..9 and flag it.
                        rsp_digit      <= (cand_digit % 4'd9) + 4'd1;
                        rsp_setup      <= lfsr_out[2:0];
                        rsp_valid      <= ONE_HOT_0 << grant_idx;
                        retry_overflow <= 1'b1;
                        state          <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gen_rand_flag <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge in_clka) disable iff (in_reset) $onehot0(rsp_valid));
    assert property (@(posedge in_clka) disable iff (in_reset) gen_rand_flag |-> busy);

endmodule

// File: tb/tb_rand_draw_scheduler.sv
// Bench for rand_draw_scheduler: an LFSR stand-in advances on gen_rand_flag and a
// draw-level model predicts winner, latency, digit and setup for every draw.
`timescale 1ns/1ps
module tb_rand_draw_scheduler;

    localparam int NREQ  = 3;
    localparam int IW    = 2;
    localparam int STEP  = 8;
    localparam int MAXR  = 15;
    localparam int MAXR2 = 2;

    logic            clk = 1'b0;
    logic            in_reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [23:0]     lfsr_out;
    logic            gen_rand_flag;
    logic [NREQ-1:0] rsp_valid;
    logic [3:0]      rsp_digit;
    logic [2:0]      rsp_setup;
    logic            busy;
    logic            retry_overflow;

    logic [NREQ-1:0] req2 = '0;
    logic [23:0]     lfsr2 = '0;
    logic            gen2;
    logic [NREQ-1:0] rsp_valid2;
    logic [3:0]      rsp_digit2;
    logic [2:0]      rsp_setup2;
    logic            busy2;
    logic            ovf2;

    int checks = 0;
    int errors = 0;

    logic [23:0] lfsr_mem [4096];
    int steps  = 0;
    int steps2 = 0;
    int cyc    = 0;

    int              model_rr  = NREQ - 1;
    int              exp_steps = 0;
    logic            exp_ovf   = 1'b0;
    logic [NREQ-1:0] keep_mask   = '0;
    logic [NREQ-1:0] drop_early  = '0;
    logic [NREQ-1:0] arrive_mask = '0;
    logic [NREQ-1:0] last_rsp;
    int              last_rsp_cyc = 0;

    rand_draw_scheduler #(.NUM_REQ(NREQ), .STEP_CNT(STEP), .MAX_RETRY(MAXR)) dut (
        .in_clka(clk), .in_reset(in_reset), .req_valid(req_valid), .lfsr_out(lfsr_out),
        .gen_rand_flag(gen_rand_flag), .rsp_valid(rsp_valid), .rsp_digit(rsp_digit),
        .rsp_setup(rsp_setup), .busy(busy), .retry_overflow(retry_overflow)
    );

    rand_draw_scheduler #(.NUM_REQ(NREQ), .STEP_CNT(STEP), .MAX_RETRY(MAXR2)) dut_r2 (
        .in_clka(clk), .in_reset(in_reset), .req_valid(req2), .lfsr_out(lfsr2),
        .gen_rand_flag(gen2), .rsp_valid(rsp_valid2), .rsp_digit(rsp_digit2),
        .rsp_setup(rsp_setup2), .busy(busy2), .retry_overflow(ovf2)
    );

    always #5 clk = ~clk;

    // LFSR stand-in: the value seen is a table entry indexed by how many steps were requested.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gen_rand_flag) steps <= steps + 1;
        if (gen2) steps2 <= steps2 + 1;
    end
    assign lfsr_out = lfsr_mem[12'(steps)];

    task automatic force_draw(input int offset, input logic [3:0] d, input logic [2:0] s);
        lfsr_mem[12'(exp_steps + offset)] = {17'($urandom), d, s};
    endtask

    // One full draw on the main instance, starting at mid-IDLE and ending at the next mid-IDLE.
    task automatic run_draw(input string name);
        logic [NREQ-1:0] reqs, exp_rsp;
        logic [23:0] v;
        logic [3:0]  d, dig;
        logic [2:0]  setup;
        logic        exp_flag, exp_busy, done;
        int g, att, lat;
        reqs = req_valid;
        g = -1;
        for (int i = 1; i <= NREQ; i++) begin
            int idx = (model_rr + i) % NREQ;
            if (g < 0 && reqs[IW'(idx)]) g = idx;
        end
        if (g < 0) begin
            errors++;
            $display("FAIL %s: no request pending at draw start got %b want nonzero", name, reqs);
            return;
        end
        att = 0; done = 1'b0; dig = '0; v = '0;
        while (!done) begin
            v = lfsr_mem[12'(exp_steps + STEP * (att + 1))];
            d = v[6:3];
            att++;
            if (d >= 4'd1 && d <= 4'd9) begin
                dig = d; done = 1'b1;
            end else if (att > MAXR) begin
                dig = 4'((int'(d) % 9) + 1); exp_ovf = 1'b1; done = 1'b1;
            end
        end
        setup = v[2:0];
        lat = STEP + 3 + (att - 1) * (STEP + 2);
        exp_steps += STEP * att;
        model_rr = g;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            exp_flag = (c < lat) && (((c - 1) % (STEP + 2)) < STEP);
            exp_busy = (c <= lat);
            exp_rsp = '0;
            if (c == lat) exp_rsp[IW'(g)] = 1'b1;
            checks++;
            if (gen_rand_flag !== exp_flag) begin
                errors++;
                $display("FAIL %s gen_rand_flag c%0d: got %b want %b", name, c, gen_rand_flag, exp_flag);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, exp_busy);
            end
            checks++;
            if (rsp_valid !== exp_rsp) begin
                errors++;
                $display("FAIL %s rsp_valid c%0d: got %b want %b", name, c, rsp_valid, exp_rsp);
            end
            if (c == lat) begin
                checks++;
                if (rsp_digit !== dig) begin
                    errors++;
                    $display("FAIL %s rsp_digit: got %0d want %0d", name, rsp_digit, dig);
                end
                checks++;
                if (rsp_setup !== setup) begin
                    errors++;
                    $display("FAIL %s rsp_setup: got %0d want %0d", name, rsp_setup, setup);
                end
                checks++;
                if (retry_overflow !== exp_ovf) begin
                    errors++;
                    $display("FAIL %s retry_overflow: got %b want %b", name, retry_overflow, exp_ovf);
                end
                last_rsp = rsp_valid;
                last_rsp_cyc = cyc;
                req_valid[IW'(g)] = keep_mask[IW'(g)];
            end
            if (c == 1) req_valid = req_valid & ~drop_early;
            if (c == 3) req_valid = req_valid | arrive_mask;
        end
        checks++;
        if (steps !== exp_steps) begin
            errors++;
            $display("FAIL %s lfsr steps: got %0d want %0d", name, steps, exp_steps);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gen_rand_flag, rsp_valid, rsp_digit, rsp_setup, busy, retry_overflow} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %b/%b/%0d/%0d/%b/%b want all 0",
                     gen_rand_flag, rsp_valid, rsp_digit, rsp_setup, busy, retry_overflow);
        end
        checks++;
        if ({gen2, rsp_valid2, rsp_digit2, rsp_setup2, busy2, ovf2} !== '0) begin
            errors++;
            $display("FAIL reset outputs r2: got %b/%b/%0d/%0d/%b/%b want all 0",
                     gen2, rsp_valid2, rsp_digit2, rsp_setup2, busy2, ovf2);
        end
        in_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        int prev;
        req_valid = 3'b111;
        keep_mask = 3'b111;
        prev = 0;
        for (int j = 0; j < 6; j++) begin
            force_draw(STEP, 4'($urandom_range(9, 1)), 3'($urandom));
            run_draw("round_robin");
            want = '0;
            want[IW'(j % NREQ)] = 1'b1;
            checks++;
            if (last_rsp !== want) begin
                errors++;
                $display("FAIL rr_order draw %0d: got %b want %b", j, last_rsp, want);
            end
            if (j > 0) begin
                checks++;
                if (last_rsp_cyc - prev !== STEP + 4) begin
                    errors++;
                    $display("FAIL rr_spacing draw %0d: got %0d want %0d", j, last_rsp_cyc - prev, STEP + 4);
                end
            end
            prev = last_rsp_cyc;
        end
        req_valid = '0;
        keep_mask = '0;
    endtask

    task automatic test_single();
        int t0;
        req_valid = 3'b001;
        force_draw(STEP, 4'd5, 3'd6);
        t0 = cyc;
        run_draw("single");
        checks++;
        if (last_rsp !== 3'b001 || rsp_digit !== 4'd5 || rsp_setup !== 3'd6 || last_rsp_cyc - t0 !== 11) begin
            errors++;
            $display("FAIL single_const: got rsp %b digit %0d setup %0d lat %0d want 001 5 6 11",
                     last_rsp, rsp_digit, rsp_setup, last_rsp_cyc - t0);
        end
    endtask

    task automatic test_retries();
        int t0, s0;
        req_valid = 3'b100;
        force_draw(STEP,     4'd0,  3'($urandom));
        force_draw(2 * STEP, 4'd12, 3'($urandom));
        force_draw(3 * STEP, 4'd9,  3'd3);
        t0 = cyc;
        s0 = steps;
        run_draw("retries");
        checks++;
        if (last_rsp_cyc - t0 !== 31 || steps - s0 !== 24 || rsp_digit !== 4'd9 || retry_overflow !== 1'b0) begin
            errors++;
            $display("FAIL retries_const: got lat %0d steps %0d digit %0d ovf %b want 31 24 9 0",
                     last_rsp_cyc - t0, steps - s0, rsp_digit, retry_overflow);
        end
    endtask

    task automatic test_drop_early();
        req_valid  = 3'b010;
        drop_early = 3'b010;
        force_draw(STEP, 4'($urandom_range(9, 1)), 3'($urandom));
        run_draw("drop_early");
        drop_early = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rsp_valid !== '0) begin
                errors++;
                $display("FAIL drop_no_regrant c%0d: got busy %b rsp %b want 0 000", c, busy, rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            if (req_valid == '0) req_valid = NREQ'($urandom_range(7, 1));
            keep_mask   = NREQ'($urandom);
            arrive_mask = ($urandom_range(3, 0) == 0) ? NREQ'($urandom) : '0;
            run_draw("random");
        end
        keep_mask   = '0;
        arrive_mask = '0;
        req_valid   = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_draw();
        int t0;
        req_valid = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (gen_rand_flag !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset advance c%0d: got %b want 1", c, gen_rand_flag);
            end
        end
        in_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (gen_rand_flag !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0 || retry_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset abort: got flag %b busy %b rsp %b ovf %b want 0 0 000 0",
                     gen_rand_flag, busy, rsp_valid, retry_overflow);
        end
        in_reset  = 1'b0;
        req_valid = '0;
        exp_steps += 4;
        model_rr  = NREQ - 1;
        exp_ovf   = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== '0 || gen_rand_flag !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset quiet c%0d: got rsp %b flag %b want 000 0", c, rsp_valid, gen_rand_flag);
            end
        end
        checks++;
        if (steps !== exp_steps) begin
            errors++;
            $display("FAIL mid_reset steps: got %0d want %0d", steps, exp_steps);
        end
        req_valid = 3'b100;
        force_draw(STEP, 4'($urandom_range(9, 1)), 3'($urandom));
        t0 = cyc;
        run_draw("after_reset");
        checks++;
        if (last_rsp !== 3'b100 || last_rsp_cyc - t0 !== 11) begin
            errors++;
            $display("FAIL after_reset_const: got rsp %b lat %0d want 100 11", last_rsp, last_rsp_cyc - t0);
        end
    endtask

    // Draw on the MAX_RETRY=2 instance, whose LFSR input is held constant by the bench.
    task automatic draw2(input string name, input logic [NREQ-1:0] req, input int lat, input int pulses,
                         input logic [3:0] dig, input logic [2:0] setup);
        logic exp_flag;
        int s0;
        s0 = steps2;
        req2 = req;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            exp_flag = (c < lat) && (((c - 1) % (STEP + 2)) < STEP);
            checks++;
            if (gen2 !== exp_flag || busy2 !== (c <= lat) || rsp_valid2 !== ((c == lat) ? req : '0)) begin
                errors++;
                $display("FAIL %s c%0d: got flag %b busy %b rsp %b want %b %b %b", name, c, gen2, busy2,
                         rsp_valid2, exp_flag, (c <= lat), ((c == lat) ? req : '0));
            end
            if (c == lat) begin
                checks++;
                if (rsp_digit2 !== dig || rsp_setup2 !== setup || ovf2 !== 1'b1) begin
                    errors++;
                    $display("FAIL %s result: got digit %0d setup %0d ovf %b want %0d %0d 1",
                             name, rsp_digit2, rsp_setup2, ovf2, dig, setup);
                end
                req2 = '0;
            end
        end
        checks++;
        if (steps2 - s0 !== pulses) begin
            errors++;
            $display("FAIL %s steps: got %0d want %0d", name, steps2 - s0, pulses);
        end
    endtask

    task automatic test_fallback();
        logic [2:0] s;
        s = 3'($urandom);
        lfsr2 = {17'($urandom), 4'd15, s};
        draw2("fallback", 3'b001, 31, 24, 4'd7, s);
        lfsr2 = {17'($urandom), 4'd3, 3'd5};
        draw2("after_fallback", 3'b010, 11, 8, 4'd3, 3'd5);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) lfsr_mem[i] = 24'($urandom);
        test_reset();
        test_round_robin();
        test_single();
        test_retries();
        test_drop_early();
        test_random();
        test_reset_mid_draw();
        test_fallback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
